acc_cpu: RTL and testbench
==========================

# acc_cpu

Parametrised accumulator CPU: the next generation of the team's 2-bit-opcode fetch/execute core, with configurable data and address width, an 8-instruction set including arithmetic and jumps, and a `mem_rdy` wait-state handshake. It sits between the port buffers (`buff_in`/`buff_out`) and a shared address/data bus to program EPROM (address MSB = 1) and data SRAM (address MSB = 0). Separate `data_in`/`data_out` replace the bidirectional bus; the top level owns any tri-state.

## Interface
- `DW`, 8, data/instruction width; must satisfy `DW >= AW + 2`
- `AW`, 5, bus address width; MSB selects program space, low `AW-1` bits are PC / operand
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `adr_bus`  out  AW  bus address
- `data_in`  in  DW  read data from memory, sampled on the edge where `rd && mem_rdy`
- `data_out`  out  DW  write data (equals `acc` while `wr`)
- `rd`, `wr`  out  1  bus strobes, never both high
- `mem_rdy`  in  1  memory completes current access on this edge when high
- `buff_in`  in  DW  input port
- `buff_out`  out  DW  output port register
- `buff_out_vld`  out  1  one-cycle pulse when `buff_out` updates
- `zero`  out  1  `acc == 0`, combinational from `acc`
- `carry`  out  1  carry/borrow of last ADD/SUB

## Operation
- Instruction: opcode = `ir[DW-1:DW-3]`, operand = `ir[AW-2:0]`, other bits ignored.
- Opcodes: 000 IN (`acc<=buff_in`), 001 OUT (`buff_out<=acc`, pulse vld), 010 STA (`mem[op]<=acc`), 011 LDA, 100 ADD (`{carry,acc}<=acc+mem`), 101 SUB (`acc<=acc-mem`, `carry<=` borrow), 110 JZ (`pc<=op` if `zero`), 111 JMP.
- States: FETCH, EXEC, MEM.
  - FETCH: `adr_bus={1,pc}`, `rd=1`. On `mem_rdy`: `ir<=data_in`, `pc<=pc+1` (mod 2^(AW-1)), go EXEC; else hold.
  - EXEC: no bus access (`rd=wr=0`). IN/OUT/JZ/JMP complete here, go FETCH. STA/LDA/ADD/SUB go MEM.
  - MEM: `adr_bus={0,op}`; STA drives `wr=1`, others `rd=1`. On `mem_rdy` complete op, go FETCH; else hold with address, strobe and `data_out` stable.
- JZ tests `zero` as it stands in EXEC (result of previous instruction).
- Bus outputs decoded from registered state/ir/pc only; no combinational input-to-output path. `rd`/`wr` forced 0 while `rst` high.
- Arithmetic is DW-bit modular; `carry` updated only by ADD/SUB.

## Timing
- Reset values: state FETCH, `pc=0`, `ir=0`, `acc=0`, `carry=0`, `buff_out=0`, `buff_out_vld=0`; first cycle after `rst` falls: `adr_bus={1,0}`, `rd=1`.
- Zero wait states: IN/OUT/JZ/JMP take 2 cycles, STA/LDA/ADD/SUB 3 cycles. Each low `mem_rdy` cycle adds one.
- `buff_out` and `buff_out_vld` change on the edge leaving EXEC for OUT; vld is low the following cycle unless another OUT completes.
- Reset mid-access: aborts immediately (`wr` low in the `rst` cycle), no register update from the aborted op.
- PC wrap: instruction at `{1, all-ones}` is followed by fetch at `{1,0}`.

## Structure
- `acc_cpu_pkg`: opcode enum (8 values), state enum (FETCH/EXEC/MEM), opcode field position helpers.
- Sub-module `acc_cpu_alu`: combinational DW-bit add/sub with carry/borrow out; the rest stays in `acc_cpu`.

## Test plan
- Reset: `rst` high 2 cycles then low -> `adr_bus=0x10`, `rd=1`, `wr=0`, `buff_out=0`, `buff_out_vld=0`, `carry=0`.
- Program IN; OUT with `buff_in=7`, `mem_rdy` tied 1 -> `buff_out=7`, single vld pulse 4 cycles after reset release.
- IN (200); STA 3; IN (100); ADD 3; OUT -> `buff_out=44`, `carry=1`; repeat with 7 and 9 -> `buff_out=16`, `carry=0`; SRAM[3] holds first input.
- IN (5); STA 2; SUB 2; JZ 0xA -> `acc=0`, `carry=0`, next fetch at `adr_bus=0x1A`; with `acc=4`, `carry=1` and fetch continues at next sequential address.
- `mem_rdy` low 3 cycles during LDA -> `rd`, `adr_bus` stable 4 cycles, `acc` changes only on the `mem_rdy` edge; same stall in FETCH holds `pc`.
- JMP 0xF then NOP-equivalent JZ with `acc != 0` -> fetches `0x1F` then `0x10`; `rst` asserted during STA wait state -> `wr` drops that cycle, SRAM unchanged.

Source files
------------

// File: rtl/acc_cpu_pkg.sv
// acc_cpu_pkg: shared definitions for the accumulator CPU.
//   - opcode_e : the eight instruction opcodes (3-bit field at the top of ir)
//   - StFetch/StExec/StMem : sequencer state encodings
//   - opc_lsb() : bit position of the opcode field for a given data width
package acc_cpu_pkg;

  localparam int unsigned OPC_W = 3;

  typedef enum logic [OPC_W-1:0] {
    OpIn  = 3'b000,
    OpOut = 3'b001,
    OpSta = 3'b010,
    OpLda = 3'b011,
    OpAdd = 3'b100,
    OpSub = 3'b101,
    OpJz  = 3'b110,
    OpJmp = 3'b111
  } opcode_e;

  localparam logic [1:0] StFetch = 2'd0;
  localparam logic [1:0] StExec  = 2'd1;
  localparam logic [1:0] StMem   = 2'd2;

  // Opcode occupies ir[dw-1 -: OPC_W].
  function automatic int unsigned opc_lsb(input int unsigned dw);
    return dw - OPC_W;
  endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// acc_cpu_alu: combinational DW-bit adder/subtractor.
// Ports:
//   i_a, i_b : operands (i_a is the accumulator)
//   i_sub    : 1 = i_a - i_b, 0 = i_a + i_b
//   o_y      : DW-bit modular result
//   o_c      : carry out for add, borrow for subtract
module acc_cpu_alu #(
  parameter int unsigned DW = 8
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic          i_sub,
  output logic [DW-1:0] o_y,
  output logic          o_c
);

  logic [DW:0] w_sum;

  // Extending both operands by one zero bit makes the MSB of the difference
  // the borrow directly.
  always_comb begin
    if (i_sub) begin
      w_sum = {1'b0, i_a} - {1'b0, i_b};
    end else begin
      w_sum = {1'b0, i_a} + {1'b0, i_b};
    end
  end

  assign o_y = w_sum[DW-1:0];
  assign o_c = w_sum[DW];

endmodule

// File: rtl/acc_cpu.sv
// acc_cpu: parametrised accumulator CPU with FETCH/EXEC/MEM sequencer.
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset
//   o_adr_bus        : bus address, MSB 1 = program EPROM, 0 = data SRAM
//   i_data_in        : read data, taken on the edge where rd && i_mem_rdy
//   o_data_out       : write data (the accumulator)
//   o_rd, o_wr       : bus strobes, never both high, low during reset
//   i_mem_rdy        : memory completes the current access on this edge
//   i_buff_in        : input port
//   o_buff_out       : output port register, o_buff_out_vld pulses on update
//   o_zero, o_carry  : accumulator zero flag, carry/borrow of last ADD/SUB
module acc_cpu
  import acc_cpu_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic [AW-1:0] o_adr_bus,
  input  logic [DW-1:0] i_data_in,
  output logic [DW-1:0] o_data_out,
  output logic          o_rd,
  output logic          o_wr,
  input  logic          i_mem_rdy,
  input  logic [DW-1:0] i_buff_in,
  output logic [DW-1:0] o_buff_out,
  output logic          o_buff_out_vld,
  output logic          o_zero,
  output logic          o_carry
);

  localparam int unsigned  OpcLsb = opc_lsb(DW);
  localparam logic [AW-2:0] PcOne = 1;

  logic [1:0]    r_state;
  logic [AW-2:0] r_pc;
  logic [DW-1:0] r_ir;
  logic [DW-1:0] r_acc;
  logic          r_carry;
  logic [DW-1:0] r_buff_out;
  logic          r_buff_out_vld;

  opcode_e       w_opc;
  logic [AW-2:0] w_operand;
  logic          w_zero;
  logic [DW-1:0] w_alu_y;
  logic          w_alu_c;
  logic          w_unused_ir;

  assign w_opc     = opcode_e'(r_ir[OpcLsb +: OPC_W]);
  assign w_operand = r_ir[AW-2:0];
  assign w_zero    = (r_acc == '0);
  // Bits between operand and opcode carry no meaning.
  assign w_unused_ir = ^r_ir[OpcLsb-1:AW-1];

  acc_cpu_alu #(
    .DW (DW)
  ) u_alu (
    .i_a   (r_acc),
    .i_b   (i_data_in),
    .i_sub (w_opc == OpSub),
    .o_y   (w_alu_y),
    .o_c   (w_alu_c)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= StFetch;
      r_pc           <= '0;
      r_ir           <= '0;
      r_acc          <= '0;
      r_carry        <= 1'b0;
      r_buff_out     <= '0;
      r_buff_out_vld <= 1'b0;
    end else begin
      r_buff_out_vld <= 1'b0;
      unique case (r_state)
        StFetch: begin
          if (i_mem_rdy) begin
            r_ir    <= i_data_in;
            r_pc    <= r_pc + PcOne;
            r_state <= StExec;
          end
        end
        StExec: begin
          r_state <= StFetch;
          case (w_opc)
            OpIn:  r_acc <= i_buff_in;
            OpOut: begin
              r_buff_out     <= r_acc;
              r_buff_out_vld <= 1'b1;
            end
            OpJz: begin
              if (w_zero) r_pc <= w_operand;
            end
            OpJmp: r_pc <= w_operand;
            default: r_state <= StMem;
          endcase
        end
        StMem: begin
          if (i_mem_rdy) begin
            r_state <= StFetch;
            case (w_opc)
              OpLda: r_acc <= i_data_in;
              OpAdd, OpSub: begin
                r_acc   <= w_alu_y;
                r_carry <= w_alu_c;
              end
              default: ;
            endcase
          end
        end
        default: r_state <= StFetch;
      endcase
    end
  end

  // Bus decode from registered state only; reset gates the strobes so an
  // in-flight access is aborted in the reset cycle itself.
  always_comb begin
    o_adr_bus = {1'b1, r_pc};
    o_rd      = 1'b0;
    o_wr      = 1'b0;
    unique case (r_state)
      StFetch: o_rd = 1'b1;
      StExec:  ;
      StMem: begin
        o_adr_bus = {1'b0, w_operand};
        if (w_opc == OpSta) o_wr = 1'b1;
        else                o_rd = 1'b1;
      end
      default: ;
    endcase
    if (i_rst) begin
      o_rd = 1'b0;
      o_wr = 1'b0;
    end
  end

  assign o_data_out     = r_acc;
  assign o_buff_out     = r_buff_out;
  assign o_buff_out_vld = r_buff_out_vld;
  assign o_zero         = w_zero;
  assign o_carry        = r_carry;

endmodule

// File: tb/tb_acc_cpu.sv
module tb_acc_cpu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] adr;
  logic [7:0] din, dout, buff_in, buff_out;
  logic       rd, wr, mem_rdy, vld, zero, carry;

  logic [7:0] prog [16];
  logic [7:0] sram [16];
  logic       sram_clr;
  int         cyc;

  typedef struct {
    logic [7:0] data;
    logic       c;
  } exp_t;
  exp_t sb[$];

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [2:0] I_IN = 3'd0, I_OUT = 3'd1, I_STA = 3'd2, I_LDA = 3'd3;
  localparam logic [2:0] I_ADD = 3'd4, I_SUB = 3'd5, I_JZ = 3'd6, I_JMP = 3'd7;

  always #5 clk = ~clk;

  acc_cpu dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .o_adr_bus      (adr),
    .i_data_in      (din),
    .o_data_out     (dout),
    .o_rd           (rd),
    .o_wr           (wr),
    .i_mem_rdy      (mem_rdy),
    .i_buff_in      (buff_in),
    .o_buff_out     (buff_out),
    .o_buff_out_vld (vld),
    .o_zero         (zero),
    .o_carry        (carry)
  );

  // Memory model: EPROM when adr[4]=1, SRAM otherwise.
  assign din = adr[4] ? prog[adr[3:0]] : sram[adr[3:0]];

  always @(posedge clk) begin
    if (sram_clr) begin
      for (int i = 0; i < 16; i++) sram[i] <= 8'h00;
    end else if (wr && mem_rdy) begin
      sram[adr[3:0]] <= dout;
    end
  end

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  function automatic logic [7:0] ins(input logic [2:0] op, input logic [3:0] a);
    return {op, 1'b0, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard monitor: every output-port pulse pops one expectation.
  always @(negedge clk) begin
    if (!rst && vld) begin
      if (sb.size() == 0) begin
        check("vld_without_expectation", {31'b0, vld}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_buff_out", {24'b0, buff_out}, {24'b0, e.data});
        check("sb_carry", {31'b0, carry}, {31'b0, e.c});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    sram_clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    sram_clr = 1'b0;
  endtask

  // Advance to cycle c after reset release, sampling 1 time unit past the negedge.
  task automatic wait_cyc(input int c);
    int n = 0;
    while (cyc < c && n < 200) begin
      @(negedge clk);
      n++;
    end
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, sb.size(), 32'd0);
    sb.delete();
  endtask

  task automatic fill_prog();
    for (int i = 0; i < 16; i++) prog[i] = ins(I_JMP, i[3:0]);
  endtask

  initial begin
    mem_rdy  = 1'b1;
    buff_in  = 8'h00;
    sram_clr = 1'b1;

    // Reset state, then IN; OUT with buff_in = 7.
    fill_prog();
    prog[0] = ins(I_IN, 4'h0);
    prog[1] = ins(I_OUT, 4'h0);
    buff_in = 8'd7;
    do_reset();
    #1;
    check("rst_adr", {27'b0, adr}, 32'h10);
    check("rst_rd", {31'b0, rd}, 32'd1);
    check("rst_wr", {31'b0, wr}, 32'd0);
    check("rst_buff_out", {24'b0, buff_out}, 32'd0);
    check("rst_vld", {31'b0, vld}, 32'd0);
    check("rst_carry", {31'b0, carry}, 32'd0);
    sb.push_back('{data: 8'd7, c: 1'b0});
    wait_cyc(3);
    check("vld_before_4", {31'b0, vld}, 32'd0);
    wait_cyc(4);
    check("vld_at_4", {31'b0, vld}, 32'd1);
    wait_cyc(5);
    check("vld_after_4", {31'b0, vld}, 32'd0);
    drain("drain_out7");

    // IN a; STA 3; IN b; ADD 3; OUT
    fill_prog();
    prog[0] = ins(I_IN, 4'h0);
    prog[1] = ins(I_STA, 4'h3);
    prog[2] = ins(I_IN, 4'h0);
    prog[3] = ins(I_ADD, 4'h3);
    prog[4] = ins(I_OUT, 4'h0);
    buff_in = 8'd200;
    do_reset();
    sb.push_back('{data: 8'd44, c: 1'b1});
    wait_cyc(3);
    buff_in = 8'd100;
    wait_cyc(4);
    check("sta_wr", {31'b0, wr}, 32'd1);
    check("sta_adr", {27'b0, adr}, 32'h03);
    check("sta_data", {24'b0, dout}, 32'd200);
    drain("drain_add_carry");
    check("sram3_200", {24'b0, sram[3]}, 32'd200);

    buff_in = 8'd7;
    do_reset();
    sb.push_back('{data: 8'd16, c: 1'b0});
    wait_cyc(3);
    buff_in = 8'd9;
    drain("drain_add_nocarry");
    check("sram3_7", {24'b0, sram[3]}, 32'd7);

    // IN 5; STA 2; SUB 2; JZ A -> taken
    fill_prog();
    prog[0] = ins(I_IN, 4'h0);
    prog[1] = ins(I_STA, 4'h2);
    prog[2] = ins(I_SUB, 4'h2);
    prog[3] = ins(I_JZ, 4'hA);
    buff_in = 8'd5;
    do_reset();
    wait_cyc(9);
    check("jz_zero", {31'b0, zero}, 32'd1);
    check("jz_carry0", {31'b0, carry}, 32'd0);
    check("exec_rd0", {31'b0, rd}, 32'd0);
    wait_cyc(10);
    check("jz_taken_adr", {27'b0, adr}, 32'h1A);
    check("jz_taken_rd", {31'b0, rd}, 32'd1);

    // IN 5; STA 2; IN 255; ADD 2 (acc=4, carry=1); JZ A -> not taken
    fill_prog();
    prog[0] = ins(I_IN, 4'h0);
    prog[1] = ins(I_STA, 4'h2);
    prog[2] = ins(I_IN, 4'h0);
    prog[3] = ins(I_ADD, 4'h2);
    prog[4] = ins(I_JZ, 4'hA);
    buff_in = 8'd5;
    do_reset();
    wait_cyc(3);
    buff_in = 8'd255;
    wait_cyc(11);
    check("jz_nz_zero", {31'b0, zero}, 32'd0);
    check("jz_nz_carry", {31'b0, carry}, 32'd1);
    wait_cyc(12);
    check("jz_not_taken_adr", {27'b0, adr}, 32'h15);

    // LDA with three wait states
    fill_prog();
    prog[0] = ins(I_IN, 4'h0);
    prog[1] = ins(I_STA, 4'h4);
    prog[2] = ins(I_IN, 4'h0);
    prog[3] = ins(I_LDA, 4'h4);
    prog[4] = ins(I_OUT, 4'h0);
    buff_in = 8'h55;
    do_reset();
    sb.push_back('{data: 8'h55, c: 1'b0});
    wait_cyc(3);
    buff_in = 8'h00;
    for (int k = 9; k <= 12; k++) begin
      wait_cyc(k);
      mem_rdy = (k == 12);
      check("lda_stall_rd", {31'b0, rd}, 32'd1);
      check("lda_stall_adr", {27'b0, adr}, 32'h04);
      check("lda_stall_acc", {31'b0, zero}, 32'd1);
    end
    wait_cyc(13);
    check("lda_done_acc", {31'b0, zero}, 32'd0);
    check("lda_next_fetch", {27'b0, adr}, 32'h14);
    drain("drain_lda");

    // Fetch stall holds pc
    fill_prog();
    prog[0] = ins(I_IN, 4'h0);
    prog[1] = ins(I_OUT, 4'h0);
    buff_in = 8'd3;
    mem_rdy = 1'b0;
    do_reset();
    sb.push_back('{data: 8'd3, c: 1'b0});
    for (int k = 0; k <= 3; k++) begin
      wait_cyc(k);
      mem_rdy = (k == 3);
      check("fetch_stall_adr", {27'b0, adr}, 32'h10);
      check("fetch_stall_rd", {31'b0, rd}, 32'd1);
    end
    wait_cyc(5);
    check("fetch_after_stall", {27'b0, adr}, 32'h11);
    drain("drain_fetch_stall");

    // JMP F; JZ 5 (acc!=0) at F wraps to 0
    fill_prog();
    prog[0]  = ins(I_IN, 4'h0);
    prog[1]  = ins(I_JMP, 4'hF);
    prog[15] = ins(I_JZ, 4'h5);
    buff_in  = 8'd9;
    mem_rdy  = 1'b1;
    do_reset();
    wait_cyc(4);
    check("jmp_fetch_1f", {27'b0, adr}, 32'h1F);
    wait_cyc(6);
    check("wrap_fetch_10", {27'b0, adr}, 32'h10);
    check("wrap_fetch_rd", {31'b0, rd}, 32'd1);

    // Reset during STA wait state
    fill_prog();
    prog[0] = ins(I_IN, 4'h0);
    prog[1] = ins(I_STA, 4'h6);
    buff_in = 8'h66;
    do_reset();
    wait_cyc(4);
    mem_rdy = 1'b0;
    check("sta_wait_wr", {31'b0, wr}, 32'd1);
    check("sta_wait_adr", {27'b0, adr}, 32'h06);
    check("sta_wait_data", {24'b0, dout}, 32'h66);
    wait_cyc(5);
    check("sta_hold_wr", {31'b0, wr}, 32'd1);
    rst     = 1'b1;
    mem_rdy = 1'b1;
    #1;
    check("abort_wr_low", {31'b0, wr}, 32'd0);
    check("abort_rd_low", {31'b0, rd}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_sram_unchanged", {24'b0, sram[6]}, 32'd0);
    check("abort_refetch_adr", {27'b0, adr}, 32'h10);
    check("abort_refetch_rd", {31'b0, rd}, 32'd1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
